// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counting timers behind a small byte-addressed
// register bus (CTRL / PRESET / COUNT per channel, one global STATUS register).
// Optional feature macro: MULTI_TIMER_PRESCALE_EN adds the CTRL[15:8] prescaler.
// Without it every counting cycle is a tick and CTRL[15:8] reads 0.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ_O
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CNTING = 2'd2,
    ST_INT    = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [1:0]        sel_ch_s;
  logic [1:0]        sel_reg_s;
  logic [NUM_CH-1:0] wr_ctrl_s;
  logic [NUM_CH-1:0] wr_preset_s;
  logic [NUM_CH-1:0] w1c_s;
  logic [NUM_CH-1:0] expire_s;
  logic [NUM_CH-1:0] im_s;
  logic [NUM_CH-1:0] pending_r;
  logic [31:0]       ctrl_rd_s   [NUM_CH];
  logic [31:0]       preset_rd_s [NUM_CH];
  logic [31:0]       count_rd_s  [NUM_CH];
  logic [31:0]       ctrl_sel_s;
  logic [31:0]       preset_sel_s;
  logic [31:0]       count_sel_s;
  logic [31:0]       status_rd_s;
  logic              unused_s;

  assign sel_ch_s  = ADD_I[5:4];
  assign sel_reg_s = ADD_I[3:2];
  // Byte-lane bits of the address and DAT_I bits beyond the register fields carry no meaning.
  assign unused_s  = ^{DAT_I, ADD_I[1:0]};

  // Per-channel write strobes; channel indices at or beyond NUM_CH never match.
  always_comb begin
    wr_ctrl_s   = '0;
    wr_preset_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (WE_I && (sel_ch_s == 2'(i))) begin
        wr_ctrl_s[i]   = (sel_reg_s == REG_CTRL);
        wr_preset_s[i] = (sel_reg_s == REG_PRESET);
      end else begin
        wr_ctrl_s[i]   = 1'b0;
        wr_preset_s[i] = 1'b0;
      end
    end
  end

  // STATUS is global: the channel field of the address does not matter.
  assign w1c_s = (WE_I && (sel_reg_s == REG_STATUS)) ? DAT_I[NUM_CH-1:0] : '0;

  // Pending flags: write-one-to-clear, but a simultaneous expiry keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~w1c_s) | expire_s;
    end
  end

  assign IRQ_O = |(pending_r & im_s);

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    state_t           state_r;
    logic             en_r;
    logic             im_r;
    logic [1:0]       mode_r;
    logic [7:0]       psc_s;
    logic [WIDTH-1:0] preset_r;
    logic [WIDTH-1:0] count_r;
    logic             tick_s;
    logic             count_le1_s;

    // PRESET=0 falls into the "<=1" case, so it expires on the first tick like PRESET=1.
    assign count_le1_s = (count_r <= {{(WIDTH-1){1'b0}}, 1'b1});

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [7:0] psc_r;
    logic [7:0] psc_cnt_r;

    assign psc_s  = psc_r;
    assign tick_s = (psc_cnt_r == psc_r);

    // Prescale field of CTRL.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        psc_r <= 8'd0;
      end else if (wr_ctrl_s[g]) begin
        psc_r <= DAT_I[15:8];
      end
    end

    // Prescale counter: restarts in LOAD, wraps on every tick while counting.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        psc_cnt_r <= 8'd0;
      end else if (state_r == ST_LOAD) begin
        psc_cnt_r <= 8'd0;
      end else if (en_r && (state_r == ST_CNTING)) begin
        psc_cnt_r <= tick_s ? 8'd0 : (psc_cnt_r + 8'd1);
      end
    end
`else
    assign psc_s  = 8'd0;
    assign tick_s = 1'b1;
`endif

    assign expire_s[g] = en_r && (state_r == ST_CNTING) && tick_s && count_le1_s;
    assign im_s[g]     = im_r;

    // CTRL enable/mode/IM; a bus write beats the one-shot self-clear of Enable.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en_r   <= 1'b0;
        mode_r <= 2'd0;
        im_r   <= 1'b0;
      end else if (wr_ctrl_s[g]) begin
        en_r   <= DAT_I[0];
        mode_r <= DAT_I[2:1];
        im_r   <= DAT_I[3];
      end else if (en_r && (state_r == ST_INT) && (mode_r == 2'd0)) begin
        en_r   <= 1'b0;
      end
    end

    // PRESET register, truncated to WIDTH; only sampled into COUNT in LOAD.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        preset_r <= '0;
      end else if (wr_preset_s[g]) begin
        preset_r <= DAT_I[WIDTH-1:0];
      end
    end

    // Channel FSM and COUNT; dropping Enable parks the FSM in IDLE and freezes COUNT.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_r <= ST_IDLE;
        count_r <= '0;
      end else if (!en_r) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_LOAD;
          end
          ST_LOAD: begin
            count_r <= preset_r;
            state_r <= ST_CNTING;
          end
          ST_CNTING: begin
            if (tick_s) begin
              if (count_le1_s) begin
                count_r <= '0;
                state_r <= ST_INT;
              end else begin
                count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_INT: begin
            state_r <= (mode_r == 2'd0) ? ST_IDLE : ST_LOAD;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    assign ctrl_rd_s[g]   = {16'd0, psc_s, 4'd0, im_r, mode_r, en_r};
    assign preset_rd_s[g] = 32'(preset_r);
    assign count_rd_s[g]  = 32'(count_r);
  end

  // Read mux: STATUS for any channel field, otherwise the addressed channel (0 if absent).
  always_comb begin
    ctrl_sel_s   = 32'd0;
    preset_sel_s = 32'd0;
    count_sel_s  = 32'd0;
    status_rd_s  = 32'd0;
    status_rd_s[NUM_CH-1:0] = pending_r;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_sel_s   = ctrl_sel_s   | ((sel_ch_s == 2'(i)) ? ctrl_rd_s[i]   : 32'd0);
      preset_sel_s = preset_sel_s | ((sel_ch_s == 2'(i)) ? preset_rd_s[i] : 32'd0);
      count_sel_s  = count_sel_s  | ((sel_ch_s == 2'(i)) ? count_rd_s[i]  : 32'd0);
    end
    case (sel_reg_s)
      REG_CTRL:   DAT_O = ctrl_sel_s;
      REG_PRESET: DAT_O = preset_sel_s;
      REG_COUNT:  DAT_O = count_sel_s;
      REG_STATUS: DAT_O = status_rd_s;
      default:    DAT_O = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scenarios plus randomized bus traffic, checked every cycle
// against a behavioural timer model kept in the bench.
module tb_multi_timer;

  localparam int NCH = 2;
  localparam int W   = 16;
  localparam logic [31:0] WMASK = (32'd1 << W) - 32'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  add_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        irq_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: per channel, what the timer is doing and its register contents.
  // phase: 0 waiting for enable, 1 about to load, 2 counting down, 3 just expired.
  int unsigned m_en[NCH], m_mode[NCH], m_im[NCH], m_psc[NCH];
  int unsigned m_preset[NCH], m_count[NCH], m_pc[NCH];
  int          m_phase[NCH];
  bit          m_pend[NCH];

  multi_timer #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ADD_I (add_i),
    .WE_I  (we_i),
    .DAT_I (dat_i),
    .DAT_O (dat_o),
    .IRQ_O (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int unsigned psc_eff(input int i);
`ifdef MULTI_TIMER_PRESCALE_EN
    return m_psc[i];
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_psc[i] = 0;
      m_preset[i] = 0; m_count[i] = 0; m_pc[i] = 0; m_phase[i] = 0; m_pend[i] = 1'b0;
    end
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_step(input bit we, input logic [5:0] a, input logic [31:0] d);
    int ch = int'(a[5:4]);
    int rg = int'(a[3:2]);
    bit fired[NCH];
    for (int i = 0; i < NCH; i++) begin
      bit drop_en = 1'b0;
      fired[i] = 1'b0;
      if (m_en[i] == 0) m_phase[i] = 0;
      else if (m_phase[i] == 0) m_phase[i] = 1;
      else if (m_phase[i] == 1) begin
        m_count[i] = m_preset[i]; m_pc[i] = 0; m_phase[i] = 2;
      end else if (m_phase[i] == 2) begin
        if (m_pc[i] == psc_eff(i)) begin
          m_pc[i] = 0;
          if (m_count[i] > 1) m_count[i] = m_count[i] - 1;
          else begin m_count[i] = 0; fired[i] = 1'b1; m_phase[i] = 3; end
        end else m_pc[i] = (m_pc[i] + 1) % 256;
      end else begin
        if (m_mode[i] == 0) begin drop_en = 1'b1; m_phase[i] = 0; end
        else m_phase[i] = 1;
      end
      if (drop_en) m_en[i] = 0;
    end
    if (we) begin
      if (rg == 3) begin
        for (int i = 0; i < NCH; i++) if (d[i]) m_pend[i] = 1'b0;
      end else if (ch < NCH && rg == 0) begin
        m_en[ch] = d[0]; m_mode[ch] = d[2:1]; m_im[ch] = d[3]; m_psc[ch] = d[15:8];
      end else if (ch < NCH && rg == 1) begin
        m_preset[ch] = d & WMASK;
      end
    end
    for (int i = 0; i < NCH; i++) if (fired[i]) m_pend[i] = 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int ch = int'(a[5:4]);
    int rg = int'(a[3:2]);
    logic [31:0] r = 32'd0;
    if (rg == 3) begin
      for (int i = 0; i < NCH; i++) r[i] = m_pend[i];
    end else if (ch < NCH) begin
      if (rg == 0) r = m_en[ch] | (m_mode[ch] << 1) | (m_im[ch] << 3) | (psc_eff(ch) << 8);
      else if (rg == 1) r = m_preset[ch];
      else r = m_count[ch];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_irq();
    logic [31:0] r = 32'd0;
    for (int i = 0; i < NCH; i++) if (m_pend[i] && m_im[i] != 0) r = 32'd1;
    return r;
  endfunction

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dat_o_vs_model", dat_o, model_read(add_i));
      check("irq_o_vs_model", {31'd0, irq_o}, model_irq());
    end
  end

  task automatic cycle(input bit we, input logic [5:0] a, input logic [31:0] d);
    we_i = we; add_i = a; dat_i = d;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(we, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'h08, 32'd0);
  endtask

  initial begin
    int          gap_ok;
    int          last_fire;
    int          fires;
    bit          w1c_next;
    logic [5:0]  a;
    logic [31:0] d;
    bit          w;
    int unsigned exp_cnt[9];

    reset = 1'b0; we_i = 1'b0; add_i = 6'h00; dat_i = 32'd0;
    model_reset();
    #1;
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    check("reset_ctrl0", dat_o, 32'd0);
    idle(2);
    check("reset_count0", dat_o, 32'd0);
    chk_en = 1'b1;
    reset = 1'b1;
    idle(1);

    // One-shot countdown on channel 0.
    cycle(1'b1, 6'h04, 32'd5);
    cycle(1'b1, 6'h00, 32'h9);
    cycle(1'b0, 6'h08, 32'd0);
    cycle(1'b0, 6'h08, 32'd0);
    check("oneshot_load", dat_o, 32'd5);
    for (int k = 4; k >= 0; k--) begin
      cycle(1'b0, 6'h08, 32'd0);
      check("oneshot_count", dat_o, 32'(k));
    end
    check("oneshot_irq", {31'd0, irq_o}, 32'd1);
    cycle(1'b0, 6'h00, 32'd0);
    check("oneshot_en_clear", dat_o, 32'h8);
    idle(3);
    check("oneshot_irq_hold", {31'd0, irq_o}, 32'd1);
    cycle(1'b0, 6'h0C, 32'd0);
    check("oneshot_status", dat_o, 32'h1);
    cycle(1'b1, 6'h0C, 32'h1);
    check("oneshot_w1c_irq", {31'd0, irq_o}, 32'd0);
    check("oneshot_w1c_status", dat_o, 32'd0);

    // Auto-reload on channel 1: pending every PRESET+2 cycles.
    cycle(1'b1, 6'h14, 32'd3);
    cycle(1'b1, 6'h10, 32'hB);
    gap_ok = 1; last_fire = 0; fires = 0; w1c_next = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (w1c_next) cycle(1'b1, 6'h0C, 32'h2);
      else cycle(1'b0, 6'h18, 32'd0);
      w1c_next = 1'b0;
      if (irq_o) begin
        if (fires == 0) check("reload_first", 32'(k), 32'd5);
        else check("reload_period", 32'(k - last_fire), 32'd5);
        fires++; last_fire = k; w1c_next = 1'b1;
      end
    end
    check("reload_fires", 32'(fires), 32'd3);
    cycle(1'b1, 6'h10, 32'd0);
    cycle(1'b1, 6'h0C, 32'h3);
    idle(3);

    // Both channels expire on one edge while ch0 pending is W1C'd there.
    cycle(1'b1, 6'h04, 32'd3);
    cycle(1'b1, 6'h14, 32'd2);
    cycle(1'b1, 6'h00, 32'h9);
    cycle(1'b1, 6'h10, 32'h9);
    for (int k = 0; k < 3; k++) cycle(1'b0, 6'h0C, 32'd0);
    cycle(1'b1, 6'h0C, 32'h1);
    check("same_edge_status", dat_o, 32'h3);
    cycle(1'b1, 6'h0C, 32'h3);
    idle(3);

    // Absent channel 2: reads zero, writes ignored; truncation of PRESET.
    cycle(1'b1, 6'h04, 32'hABCD_0055);
    cycle(1'b1, 6'h24, 32'hAA);
    cycle(1'b1, 6'h20, 32'hFF);
    cycle(1'b0, 6'h04, 32'd0);
    check("trunc_preset0", dat_o, 32'h55);
    cycle(1'b0, 6'h14, 32'd0);
    check("ch1_preset_kept", dat_o, 32'd2);
    cycle(1'b0, 6'h20, 32'd0);
    check("absent_ch_read", dat_o, 32'd0);
    cycle(1'b0, 6'h00, 32'd0);
    check("ch0_ctrl_kept", dat_o, 32'h8);

    // Prescaler (or its absence) on channel 0 with PSC=3, PRESET=2.
`ifdef MULTI_TIMER_PRESCALE_EN
    exp_cnt = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
`else
    exp_cnt = '{2, 1, 0, 0, 0, 0, 0, 0, 0};
`endif
    cycle(1'b1, 6'h04, 32'd2);
    cycle(1'b1, 6'h00, 32'h301);
    cycle(1'b0, 6'h08, 32'd0);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 6'h08, 32'd0);
      check("psc_count", dat_o, 32'(exp_cnt[k]));
    end
    idle(2);
    cycle(1'b0, 6'h00, 32'd0);
`ifdef MULTI_TIMER_PRESCALE_EN
    check("psc_ctrl", dat_o, 32'h300);
`else
    check("psc_ctrl", dat_o, 32'h000);
`endif
    cycle(1'b1, 6'h0C, 32'h3);
    idle(2);

    // Reset mid-count at COUNT=7 with an interrupt outstanding on ch1.
    cycle(1'b1, 6'h14, 32'd0);
    cycle(1'b1, 6'h10, 32'h9);
    cycle(1'b1, 6'h04, 32'd9);
    cycle(1'b1, 6'h00, 32'h9);
    for (int k = 0; k < 4; k++) cycle(1'b0, 6'h08, 32'd0);
    check("pre_reset_count", dat_o, 32'd7);
    check("pre_reset_irq", {31'd0, irq_o}, 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_async_count", dat_o, 32'd0);
    check("reset_async_irq", {31'd0, irq_o}, 32'd0);
    cycle(1'b1, 6'h04, 32'hFF);
    cycle(1'b0, 6'h04, 32'd0);
    check("reset_write_ignored", dat_o, 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 6'h00, 32'd0);
      check("post_reset_no_irq", {31'd0, irq_o}, 32'd0);
    end
    check("post_reset_ctrl", dat_o, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 6'($urandom), $urandom);
        cycle(1'b1, 6'($urandom), $urandom);
        reset = 1'b1;
      end else begin
        a = 6'($urandom_range(0, 63));
        w = ($urandom_range(0, 9) < 3);
        d = $urandom;
        if (a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 12));
        if (a[3:2] == 2'd0) begin
          d = (d & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
          if ($urandom_range(0, 9) < 7) d = d | 32'd1;
        end
        cycle(w, a, d);
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
